systolic_tile_sched: RTL and testbench

Tile scheduler for the N×N output-stationary systolic array computing an M×M product as (M/N)² output tiles. On a start pulse it walks every output tile, issues operand-memory read addresses for the A and B banks, and generates the `init` pulse that seeds the PE[0][0] wavefront. It also flushes the final tile and counts completed tiles from the array's last-PE valid. It sits between the host start/done handshake and the operand memories plus array.

---
 rtl/systolic_tile_sched_pkg.sv | 32 +++
 rtl/systolic_tile_sched_if.sv | 32 +++
 rtl/systolic_tile_sched_delay_line.sv | 28 ++
 rtl/systolic_tile_sched.sv | 149 ++++++++++++++
 tb/tb_systolic_tile_sched.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/systolic_tile_sched_pkg.sv
// Shared types and elaboration-time helpers for the systolic tile scheduler.
// Ports: none (package).
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } sched_state_t;

    // $clog2 that never returns 0, so single-valued counters still get a bit.
    function automatic int safe_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Tiles per matrix edge.
    function automatic int calc_t(input int m, input int n);
        return m / n;
    endfunction

    // Operand read-address width.
    function automatic int calc_aw(input int m, input int n);
        return safe_clog2(m * m / n);
    endfunction

    // Tile-index width.
    function automatic int calc_tw(input int m, input int n);
        return safe_clog2(calc_t(m, n) * calc_t(m, n));
    endfunction

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Handshake/bus bundle between the tile scheduler, the host, the operand
// memories and the systolic array.
//   master : scheduler side (drives busy/done, read port, init/zero, tile_done)
//   slave  : host + memory + array side (drives start, valid_last)
interface systolic_tile_sched_if #(
    parameter int AW = 4,
    parameter int TW = 2
);
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr_A;
    logic [AW-1:0] rd_addr_B;
    logic          zero_ops;
    logic          init_00;
    logic          valid_last;
    logic          tile_done;
    logic [TW-1:0] tile_done_idx;

    modport master (
        input  start, valid_last,
        output busy, done, rd_en, rd_addr_A, rd_addr_B,
               zero_ops, init_00, tile_done, tile_done_idx
    );

    modport slave (
        output start, valid_last,
        input  busy, done, rd_en, rd_addr_A, rd_addr_B,
               zero_ops, init_00, tile_done, tile_done_idx
    );
endinterface

// File: rtl/systolic_tile_sched_delay_line.sv
// DEPTH-stage, 2-bit shift register aligning the {init, zero} markers with
// operand arrival from memory. Async active-low clear drops in-flight markers.
//   clk, rst_n : clock, async active-low clear
//   din        : {init marker, zero marker} launched this cycle
//   dout       : same markers, DEPTH cycles later
module sched_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] din,
    output logic [1:0] dout
);
    logic [DEPTH-1:0][1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/systolic_tile_sched.sv
// Output-stationary systolic tile scheduler. Walks the (M/N)^2 output tiles
// row-major, streams A/B operand addresses, seeds PE[0][0] with init, flushes
// the final tile and reports each completed tile from the last PE's valid.
//   clk, rst : clock, async active-low reset
//   bus      : master side of systolic_tile_sched_if (start/busy/done,
//              operand read port, init_00/zero_ops, valid_last, tile_done)
module systolic_tile_sched
    import systolic_pkg::*;
#(
    parameter int N      = 3,
    parameter int M      = 6,
    parameter int RD_LAT = 1,
    parameter int AW     = calc_aw(M, N),
    parameter int TW     = calc_tw(M, N)
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_tile_sched_if.master bus
);
    localparam int T       = calc_t(M, N);
    localparam int KW      = safe_clog2(M);
    localparam int IW      = safe_clog2(T);
    localparam int CW      = safe_clog2(T * T + 2);
    // One extra valid_last: the first init flushes an empty accumulator.
    localparam int RESULTS = T * T + 1;

    sched_state_t  state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [IW-1:0] ti_q, ti_d, tj_q, tj_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          tile_done_q, tile_done_d;
    logic [TW-1:0] idx_q, idx_d;

    logic k_last, tj_last, ti_last, results_in;
    logic rd_en, busy, flush, marker;
    logic [1:0] dly_out;

    assign k_last     = (k_q == KW'(M - 1));
    assign tj_last    = (tj_q == IW'(T - 1));
    assign ti_last    = (ti_q == IW'(T - 1));
    assign results_in = (cnt_q == CW'(RESULTS));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = STREAM;
            STREAM:  if (k_last && tj_last && ti_last) state_d = FLUSH;
            FLUSH:   state_d = DRAIN;
            DRAIN:   if (results_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en  = (state_q == STREAM);
        busy   = (state_q != IDLE);
        flush  = (state_q == FLUSH);
        marker = (rd_en && (k_q == '0)) || flush;
        done_d = (state_q == DRAIN) && results_in;
    end

    // ---------------- Counters ----------------
    always_comb begin
        k_d         = k_q;
        ti_d        = ti_q;
        tj_d        = tj_q;
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        idx_d       = idx_q;

        if (state_q == IDLE) begin
            if (bus.start) begin
                k_d   = '0;
                ti_d  = '0;
                tj_d  = '0;
                cnt_d = '0;
            end
        end else if (bus.valid_last) begin
            cnt_d = cnt_q + CW'(1);
            // Pulse n reports tile n-1; pulse 0 is the empty first flush.
            if (cnt_q != '0) begin
                tile_done_d = 1'b1;
                idx_d       = TW'(cnt_q - CW'(1));
            end
        end

        if (state_q == STREAM) begin
            if (k_last) begin
                k_d = '0;
                if (tj_last) begin
                    tj_d = '0;
                    ti_d = ti_last ? '0 : ti_q + IW'(1);
                end else begin
                    tj_d = tj_q + IW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q         <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            tile_done_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            k_q         <= k_d;
            ti_q        <= ti_d;
            tj_q        <= tj_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            tile_done_q <= tile_done_d;
            idx_q       <= idx_d;
        end
    end

    // Markers ride alongside the operand reads so init/zero land with data.
    sched_delay_line #(.DEPTH(RD_LAT)) u_dly (
        .clk   (clk),
        .rst_n (rst),
        .din   ({marker, flush}),
        .dout  (dly_out)
    );

    assign bus.busy          = busy;
    assign bus.done          = done_q;
    assign bus.rd_en         = rd_en;
    // Full-width products, truncated: max address < M*M/N by construction.
    assign bus.rd_addr_A     = AW'(32'(ti_q) * 32'(M) + 32'(k_q));
    assign bus.rd_addr_B     = AW'(32'(tj_q) * 32'(M) + 32'(k_q));
    assign bus.init_00       = dly_out[1];
    assign bus.zero_ops      = dly_out[0];
    assign bus.tile_done     = tile_done_q;
    assign bus.tile_done_idx = idx_q;
endmodule

// File: tb/tb_systolic_tile_sched.sv
module tb_systolic_tile_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spur = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    systolic_tile_sched_if #(.AW(4), .TW(2)) ifa ();
    systolic_tile_sched_if #(.AW(2), .TW(1)) ifb ();

    systolic_tile_sched #(.N(3), .M(6), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master));
    systolic_tile_sched #(.N(3), .M(3), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master));

    // Array model: last-PE valid appears 2N-1 cycles after each init_00.
    logic [5:0] sra, srb;
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            sra <= '0;
            srb <= '0;
        end else begin
            sra <= {sra[4:0], ifa.init_00};
            srb <= {srb[4:0], ifb.init_00};
        end
    end
    assign ifa.valid_last = sra[5] | spur;
    assign ifb.valid_last = srb[5] | spur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_a(input int c);
        chk($sformatf("rst_busy@%0d", c),  32'(ifa.busy), 0);
        chk($sformatf("rst_done@%0d", c),  32'(ifa.done), 0);
        chk($sformatf("rst_rden@%0d", c),  32'(ifa.rd_en), 0);
        chk($sformatf("rst_addrA@%0d", c), 32'(ifa.rd_addr_A), 0);
        chk($sformatf("rst_addrB@%0d", c), 32'(ifa.rd_addr_B), 0);
        chk($sformatf("rst_zero@%0d", c),  32'(ifa.zero_ops), 0);
        chk($sformatf("rst_init@%0d", c),  32'(ifa.init_00), 0);
        chk($sformatf("rst_td@%0d", c),    32'(ifa.tile_done), 0);
        chk($sformatf("rst_idx@%0d", c),   32'(ifa.tile_done_idx), 0);
    endtask

    // One product on dut_a (N=3, M=6, RD_LAT=1), start in cycle 0.
    // s2/s3: cycles with an extra start pulse; rst_at: cycle to assert reset.
    task automatic run_a(input int s2, input int s3, input int rst_at);
        int  ea [24] = '{0,1,2,3,4,5, 0,1,2,3,4,5, 6,7,8,9,10,11, 6,7,8,9,10,11};
        int  eb [24] = '{0,1,2,3,4,5, 6,7,8,9,10,11, 0,1,2,3,4,5, 6,7,8,9,10,11};
        bit  in_rst = 1'b0;
        bit  e_init, e_td;
        @(negedge clk);
        ifa.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ifa.start = (c == s2) || (c == s3);
            if (c == rst_at) begin
                rst = 1'b0;
                in_rst = 1'b1;
                #1;
                chk_rst_a(c);
            end else if (in_rst) begin
                chk($sformatf("rstd_busy@%0d", c), 32'(ifa.busy), 0);
                chk($sformatf("rstd_done@%0d", c), 32'(ifa.done), 0);
                chk($sformatf("rstd_td@%0d", c),   32'(ifa.tile_done), 0);
                chk($sformatf("rstd_init@%0d", c), 32'(ifa.init_00), 0);
            end else begin
                e_init = (c == 2) || (c == 8) || (c == 14) || (c == 20) || (c == 26);
                e_td   = (c == 14) || (c == 20) || (c == 26) || (c == 32);
                chk($sformatf("busy@%0d", c), 32'(ifa.busy), 32'(c <= 32));
                chk($sformatf("rden@%0d", c), 32'(ifa.rd_en), 32'(c <= 24));
                if (c <= 24) begin
                    chk($sformatf("addrA@%0d", c), 32'(ifa.rd_addr_A), 32'(ea[c-1]));
                    chk($sformatf("addrB@%0d", c), 32'(ifa.rd_addr_B), 32'(eb[c-1]));
                end
                chk($sformatf("init@%0d", c), 32'(ifa.init_00), 32'(e_init));
                chk($sformatf("zero@%0d", c), 32'(ifa.zero_ops), 32'(c == 26));
                chk($sformatf("td@%0d", c), 32'(ifa.tile_done), 32'(e_td));
                if (e_td)
                    chk($sformatf("idx@%0d", c), 32'(ifa.tile_done_idx), 32'((c - 14) / 6));
                chk($sformatf("done@%0d", c), 32'(ifa.done), 32'(c == 33));
            end
        end
        ifa.start = 1'b0;
        if (in_rst) begin
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_rst_a(0);
        chk("rstb_busy", 32'(ifb.busy), 0);
        chk("rstb_init", 32'(ifb.init_00), 0);
        chk("rstb_idx",  32'(ifb.tile_done_idx), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_a(0, 0, 0);           // baseline product
        repeat (3) @(negedge clk);
        run_a(5, 15, 0);          // starts during STREAM are ignored
        repeat (3) @(negedge clk);
        run_a(0, 0, 10);          // reset mid-run
        repeat (10) @(negedge clk);
        run_a(0, 0, 0);           // fresh run after reset matches baseline

        // Spurious last-PE valids while idle must not be counted.
        spur = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) spur = 1'b0;
            chk($sformatf("spur_tdA@%0d", c), 32'(ifa.tile_done), 0);
            chk($sformatf("spur_tdB@%0d", c), 32'(ifb.tile_done), 0);
        end
        run_a(0, 0, 0);
        repeat (3) @(negedge clk);

        // Single tile: N=M=3, RD_LAT=2.
        @(negedge clk);
        ifb.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            chk($sformatf("b_busy@%0d", c), 32'(ifb.busy), 32'(c <= 12));
            chk($sformatf("b_rden@%0d", c), 32'(ifb.rd_en), 32'(c <= 3));
            if (c <= 3) begin
                chk($sformatf("b_addrA@%0d", c), 32'(ifb.rd_addr_A), 32'(c - 1));
                chk($sformatf("b_addrB@%0d", c), 32'(ifb.rd_addr_B), 32'(c - 1));
            end
            chk($sformatf("b_init@%0d", c), 32'(ifb.init_00), 32'((c == 3) || (c == 6)));
            chk($sformatf("b_zero@%0d", c), 32'(ifb.zero_ops), 32'(c == 6));
            chk($sformatf("b_td@%0d", c), 32'(ifb.tile_done), 32'(c == 12));
            if (c == 12) chk("b_idx", 32'(ifb.tile_done_idx), 0);
            chk($sformatf("b_done@%0d", c), 32'(ifb.done), 32'(c == 13));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
